// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core sequencer: the FSM state encoding,
// stage indices reported on a watchdog timeout, and the PC step.
package core_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_F_ISSUE = 4'd1,
    S_F_WAIT  = 4'd2,
    S_D_ISSUE = 4'd3,
    S_D_WAIT  = 4'd4,
    S_E_ISSUE = 4'd5,
    S_E_WAIT  = 4'd6,
    S_M_ISSUE = 4'd7,
    S_M_WAIT  = 4'd8,
    S_W_ISSUE = 4'd9,
    S_W_WAIT  = 4'd10,
    S_HALTED  = 4'd11,
    S_ERROR   = 4'd12
  } seq_state_e;

  localparam logic [2:0] STG_F = 3'd0;
  localparam logic [2:0] STG_D = 3'd1;
  localparam logic [2:0] STG_E = 3'd2;
  localparam logic [2:0] STG_M = 3'd3;
  localparam logic [2:0] STG_W = 3'd4;

  localparam logic [31:0] PC_INC = 32'd4;

  // Stage index owning a given ISSUE/WAIT state; other states map to fetch.
  function automatic logic [2:0] stage_of(seq_state_e s);
    case (s)
      S_F_ISSUE, S_F_WAIT: return STG_F;
      S_D_ISSUE, S_D_WAIT: return STG_D;
      S_E_ISSUE, S_E_WAIT: return STG_E;
      S_M_ISSUE, S_M_WAIT: return STG_M;
      S_W_ISSUE, S_W_WAIT: return STG_W;
      default:             return STG_F;
    endcase
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Bundle between the sequencer (master) and the pipeline stages / run control
// (slave).
//
// Handshake: each stage is started by X_enabled, a single-cycle pulse driven by
// the master. The stage answers with X_completed, a level that the master only
// samples while it is waiting on that same stage; the level may stay high
// afterwards and is then ignored. Side data (decode_is_mem, exec_is_jump,
// exec_jump_dest) is only meaningful in a cycle where its completed level is
// high. run and halt_req are levels looked at only at instruction boundaries.
interface core_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             run;
  logic             halt_req;
  logic [31:0]      pc;
  logic             fetch_enabled;
  logic             decode_enabled;
  logic             exec_enabled;
  logic             mem_enabled;
  logic             write_enabled;
  logic             fetch_completed;
  logic             decode_completed;
  logic             exec_completed;
  logic             mem_completed;
  logic             write_completed;
  logic             decode_is_mem;
  logic             exec_is_jump;
  logic [31:0]      exec_jump_dest;
  logic             halted;
  logic             error;
  logic [2:0]       err_stage;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  run, halt_req,
    input  fetch_completed, decode_completed, exec_completed,
    input  mem_completed, write_completed,
    input  decode_is_mem, exec_is_jump, exec_jump_dest,
    output pc,
    output fetch_enabled, decode_enabled, exec_enabled, mem_enabled, write_enabled,
    output halted, error, err_stage, cycle_cnt, instret_cnt
  );

  modport slave (
    output run, halt_req,
    output fetch_completed, decode_completed, exec_completed,
    output mem_completed, write_completed,
    output decode_is_mem, exec_is_jump, exec_jump_dest,
    input  pc,
    input  fetch_enabled, decode_enabled, exec_enabled, mem_enabled, write_enabled,
    input  halted, error, err_stage, cycle_cnt, instret_cnt
  );

endinterface

// File: rtl/seq_watchdog.sv
// Per-stage wait watchdog: counts waiting cycles without completion and flags
// expiry on the cycle whose count would reach TIMEOUT. TIMEOUT=0 disables it.
module seq_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  // Count never needs to exceed TIMEOUT-1 before the FSM leaves the wait.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear on entry to a wait, otherwise count idle wait cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry only on a tick, so a completion in the same cycle always wins.
  assign expired_o = (TIMEOUT != 0) && tick_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle core control: walks one instruction through fetch, decode, exec,
// optional mem and write, owns the PC, and handles run/halt, a per-stage
// watchdog and the cycle / retired-instruction counters.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  core_sequencer_if.master  bus,
  output seq_state_e        state_o
);

  seq_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             is_mem_q, is_mem_d;
  logic             is_jump_q, is_jump_d;
  logic [31:0]      dest_q, dest_d;
  logic [2:0]       err_stage_q, err_stage_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic stage_done;
  logic in_issue;
  logic in_wait;
  logic active;
  logic wd_expired;

  assign in_issue = state_q inside {S_F_ISSUE, S_D_ISSUE, S_E_ISSUE, S_M_ISSUE, S_W_ISSUE};
  assign in_wait  = state_q inside {S_F_WAIT, S_D_WAIT, S_E_WAIT, S_M_WAIT, S_W_WAIT};
  assign active   = !(state_q inside {S_IDLE, S_HALTED, S_ERROR});

  // Select the completed level of the stage currently being waited on.
  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      S_F_WAIT: stage_done = bus.fetch_completed;
      S_D_WAIT: stage_done = bus.decode_completed;
      S_E_WAIT: stage_done = bus.exec_completed;
      S_M_WAIT: stage_done = bus.mem_completed;
      S_W_WAIT: stage_done = bus.write_completed;
      default:  stage_done = 1'b0;
    endcase
  end

  // Every ISSUE state leads straight into its WAIT, so clearing there
  // restarts the count on entry to each wait.
  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rstn      (rstn),
    .clear_i   (in_issue),
    .tick_i    (in_wait && !stage_done),
    .expired_o (wd_expired)
  );

  // Next-state, instruction latches, PC update and counters.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    is_mem_d    = is_mem_q;
    is_jump_d   = is_jump_q;
    dest_d      = dest_q;
    err_stage_d = err_stage_q;
    instret_d   = instret_q;
    cycle_cnt_d = active ? (cycle_cnt_q + CNT_W'(1)) : cycle_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.halt_req) begin
          state_d = S_HALTED;
        end else if (bus.run) begin
          state_d = S_F_ISSUE;
        end
      end
      S_F_ISSUE: state_d = S_F_WAIT;
      S_F_WAIT:  if (stage_done) state_d = S_D_ISSUE;
      S_D_ISSUE: state_d = S_D_WAIT;
      S_D_WAIT: begin
        if (stage_done) begin
          is_mem_d = bus.decode_is_mem;
          state_d  = S_E_ISSUE;
        end
      end
      S_E_ISSUE: state_d = S_E_WAIT;
      S_E_WAIT: begin
        if (stage_done) begin
          is_jump_d = bus.exec_is_jump;
          dest_d    = bus.exec_jump_dest;
          state_d   = is_mem_q ? S_M_ISSUE : S_W_ISSUE;
        end
      end
      S_M_ISSUE: state_d = S_M_WAIT;
      S_M_WAIT:  if (stage_done) state_d = S_W_ISSUE;
      S_W_ISSUE: state_d = S_W_WAIT;
      S_W_WAIT: begin
        if (stage_done) begin
          pc_d      = is_jump_q ? dest_q : (pc_q + PC_INC);
          instret_d = instret_q + CNT_W'(1);
          if (bus.halt_req) begin
            state_d = S_HALTED;
          end else if (bus.run) begin
            state_d = S_F_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HALTED: state_d = S_HALTED;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase

    // Expiry implies no completion this cycle, so it never overrides one.
    if (wd_expired) begin
      state_d     = S_ERROR;
      err_stage_d = stage_of(state_q);
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      is_mem_q    <= 1'b0;
      is_jump_q   <= 1'b0;
      dest_q      <= '0;
      err_stage_q <= '0;
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      is_mem_q    <= is_mem_d;
      is_jump_q   <= is_jump_d;
      dest_q      <= dest_d;
      err_stage_q <= err_stage_d;
      cycle_cnt_q <= cycle_cnt_d;
      instret_q   <= instret_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.fetch_enabled  = (state_q == S_F_ISSUE);
  assign bus.decode_enabled = (state_q == S_D_ISSUE);
  assign bus.exec_enabled   = (state_q == S_E_ISSUE);
  assign bus.mem_enabled    = (state_q == S_M_ISSUE);
  assign bus.write_enabled  = (state_q == S_W_ISSUE);
  assign bus.halted         = (state_q == S_HALTED);
  assign bus.error          = (state_q == S_ERROR);
  assign bus.err_stage      = err_stage_q;
  assign bus.cycle_cnt      = cycle_cnt_q;
  assign bus.instret_cnt    = instret_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: behavioural stage models answer each enable pulse
// after a configurable latency; a monitor pops expected fetch PCs from a
// scoreboard queue and logs every enable pulse for ordering/latency checks.
module tb_core_sequencer;
  import core_seq_pkg::*;

  localparam logic [31:0] NEVER_PC = 32'hffff_fff0;

  logic       clk = 1'b0;
  logic       rstn;
  seq_state_e state;

  core_sequencer_if #(.CNT_W(32)) bus ();

  core_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (8),
    .CNT_W    (32)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  int          ev_q[$];
  int          ev_stamp[$];
  int          fetch_stamp[$];
  int          pulse_total = 0;

  // stage model configuration
  int          lat[5];
  int          cnt[5];
  bit          never_c[5];
  bit          comp[5];
  logic        en[5];
  bit          stale_f = 1'b0;
  logic [31:0] mem_pc    = NEVER_PC;
  logic [31:0] jump_pc   = NEVER_PC;
  logic [31:0] jump_dest = 32'h0;

  // ---------------- stage models ----------------
  initial begin
    for (int s = 0; s < 5; s++) begin
      lat[s] = 1; cnt[s] = 0; never_c[s] = 1'b0; comp[s] = 1'b0;
    end
    bus.fetch_completed = 1'b0; bus.decode_completed = 1'b0;
    bus.exec_completed  = 1'b0; bus.mem_completed    = 1'b0;
    bus.write_completed = 1'b0; bus.decode_is_mem    = 1'b0;
    bus.exec_is_jump    = 1'b0; bus.exec_jump_dest   = 32'h0;
    forever begin
      @(posedge clk); #1;
      en[0] = bus.fetch_enabled; en[1] = bus.decode_enabled; en[2] = bus.exec_enabled;
      en[3] = bus.mem_enabled;   en[4] = bus.write_enabled;
      for (int s = 0; s < 5; s++) begin
        comp[s] = 1'b0;
        if (cnt[s] > 0) begin
          cnt[s] = cnt[s] - 1;
          if (cnt[s] == 0) comp[s] = 1'b1;
        end
        if (en[s] === 1'b1 && !never_c[s]) cnt[s] = lat[s];
      end
      bus.fetch_completed  = comp[0] | stale_f;
      bus.decode_completed = comp[1];
      bus.exec_completed   = comp[2];
      bus.mem_completed    = comp[3];
      bus.write_completed  = comp[4];
      // side data is garbage whenever it is not qualified
      bus.decode_is_mem  = comp[1] ? (bus.pc == mem_pc) : 1'($urandom_range(0, 1));
      bus.exec_is_jump   = comp[2] ? (bus.pc == jump_pc) : 1'($urandom_range(0, 1));
      bus.exec_jump_dest = comp[2] ? jump_dest : $urandom;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0] exp_pc;
    forever begin
      @(posedge clk); #2;
      if (rstn === 1'b1) begin
        if (bus.fetch_enabled === 1'b1) begin
          fetch_stamp.push_back(cyc);
          if (exp_q.size() > 0) begin
            exp_pc = exp_q.pop_front();
            vectors++;
            if (bus.pc !== exp_pc) begin
              miscompares++;
              $display("FAIL fetch_pc: pc=%h expected %h", bus.pc, exp_pc);
            end
          end
        end
        en[0] = bus.fetch_enabled;
        if (bus.fetch_enabled === 1'b1)  begin ev_q.push_back(0); ev_stamp.push_back(cyc); pulse_total++; end
        if (bus.decode_enabled === 1'b1) begin ev_q.push_back(1); ev_stamp.push_back(cyc); pulse_total++; end
        if (bus.exec_enabled === 1'b1)   begin ev_q.push_back(2); ev_stamp.push_back(cyc); pulse_total++; end
        if (bus.mem_enabled === 1'b1)    begin ev_q.push_back(3); ev_stamp.push_back(cyc); pulse_total++; end
        if (bus.write_enabled === 1'b1)  begin ev_q.push_back(4); ev_stamp.push_back(cyc); pulse_total++; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn = 1'b0; bus.run = 1'b0; bus.halt_req = 1'b0;
    step(2);
    rstn = 1'b1;
    step(1);
  endtask

  task automatic wait_state(input seq_state_e s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (state == s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_instret(input logic [31:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (bus.instret_cnt == target) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; bus.run = 1'b0; bus.halt_req = 1'b0;
    step(2);
    vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want %0d", state, S_IDLE); end
    vectors++; if (bus.pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 0", bus.pc); end
    vectors++;
    if ({bus.fetch_enabled, bus.decode_enabled, bus.exec_enabled, bus.mem_enabled, bus.write_enabled} !== 5'b0) begin
      miscompares++; $display("FAIL rst_enables: some enable high, want all 0");
    end
    vectors++;
    if ({bus.halted, bus.error, bus.err_stage} !== 5'b0) begin
      miscompares++; $display("FAIL rst_flags: got %b want 00000", {bus.halted, bus.error, bus.err_stage});
    end
    vectors++;
    if (bus.cycle_cnt !== 32'd0 || bus.instret_cnt !== 32'd0) begin
      miscompares++; $display("FAIL rst_counters: got %0d/%0d want 0/0", bus.cycle_cnt, bus.instret_cnt);
    end
    rstn = 1'b1;
    step(3);
    vectors++;
    if (state !== S_IDLE || bus.cycle_cnt !== 32'd0) begin
      miscompares++; $display("FAIL idle_hold: state %0d cycle_cnt %0d want IDLE/0", state, bus.cycle_cnt);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    int n_mem;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hc);
    fetch_stamp.delete(); ev_q.delete(); ev_stamp.delete();
    bus.run = 1'b1;
    step(1);
    step(23);
    vectors++; if (bus.instret_cnt !== 32'd2) begin miscompares++; $display("FAIL seq_instret23: got %0d want 2", bus.instret_cnt); end
    step(1);
    vectors++; if (bus.instret_cnt !== 32'd3) begin miscompares++; $display("FAIL seq_instret24: got %0d want 3", bus.instret_cnt); end
    vectors++; if (state !== S_F_ISSUE) begin miscompares++; $display("FAIL seq_b2b: state %0d want %0d", state, S_F_ISSUE); end
    bus.run = 1'b0;
    wait_state(S_IDLE, 20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL seq_idle_timeout: state %0d want IDLE", state); end
    vectors++; if (bus.pc !== 32'h10) begin miscompares++; $display("FAIL seq_pc: got %h want 00000010", bus.pc); end
    vectors++; if (bus.cycle_cnt !== 32'd32) begin miscompares++; $display("FAIL seq_cycle_cnt: got %0d want 32", bus.cycle_cnt); end
    n_mem = 0;
    foreach (ev_q[i]) if (ev_q[i] == 3) n_mem++;
    vectors++; if (n_mem != 0) begin miscompares++; $display("FAIL seq_no_mem: got %0d mem pulses want 0", n_mem); end
    vectors++; if (fetch_stamp.size() != 4) begin miscompares++; $display("FAIL seq_fetches: got %0d want 4", fetch_stamp.size()); end
    else begin
      for (int i = 1; i < 4; i++) begin
        vectors++;
        if (fetch_stamp[i] - fetch_stamp[i-1] != 8) begin
          miscompares++; $display("FAIL seq_spacing: got %0d want 8", fetch_stamp[i] - fetch_stamp[i-1]);
        end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL seq_sb_left: got %0d left want 0", exp_q.size()); end
    step(3);
    vectors++; if (bus.cycle_cnt !== 32'd32) begin miscompares++; $display("FAIL seq_idle_cnt: got %0d want 32", bus.cycle_cnt); end
  endtask

  task automatic test_mem();
    bit ok;
    logic [31:0] c_base, i_base;
    int exp_ev[9] = '{0, 1, 2, 4, 0, 1, 2, 3, 4};
    c_base = bus.cycle_cnt; i_base = bus.instret_cnt;
    mem_pc = 32'h14;
    exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    ev_q.delete(); ev_stamp.delete();
    bus.run = 1'b1;
    wait_instret(i_base + 32'd1, 20, ok);
    bus.run = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL mem_retire1_timeout: instret %0d", bus.instret_cnt); end
    wait_state(S_IDLE, 30, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL mem_idle_timeout: state %0d", state); end
    vectors++; if (bus.cycle_cnt - c_base !== 32'd18) begin miscompares++; $display("FAIL mem_cycles: got %0d want 18", bus.cycle_cnt - c_base); end
    vectors++; if (bus.pc !== 32'h18) begin miscompares++; $display("FAIL mem_pc: got %h want 00000018", bus.pc); end
    vectors++;
    if (ev_q.size() != 9) begin
      miscompares++; $display("FAIL mem_pulse_count: got %0d want 9", ev_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        vectors++;
        if (ev_q[i] != exp_ev[i]) begin miscompares++; $display("FAIL mem_order[%0d]: got %0d want %0d", i, ev_q[i], exp_ev[i]); end
      end
    end
    mem_pc = NEVER_PC;
  endtask

  task automatic test_jump();
    bit ok;
    reset_dut();
    jump_pc = 32'h4; jump_dest = 32'h100;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    bus.run = 1'b1;
    wait_instret(32'd3, 40, ok);
    bus.run = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL jmp_retire_timeout: instret %0d", bus.instret_cnt); end
    wait_state(S_IDLE, 20, ok);
    vectors++; if (bus.pc !== 32'h108) begin miscompares++; $display("FAIL jmp_pc: got %h want 00000108", bus.pc); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL jmp_sb_left: got %0d left want 0", exp_q.size()); end
    jump_pc = NEVER_PC;
  endtask

  task automatic test_stale_fetch();
    bit ok;
    logic [31:0] c_base;
    c_base = bus.cycle_cnt;
    stale_f = 1'b1; lat[1] = 3;
    exp_q.push_back(32'h108);
    ev_q.delete(); ev_stamp.delete();
    step(2);
    bus.run = 1'b1;
    step(1);
    bus.run = 1'b0;
    wait_state(S_IDLE, 30, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stale_idle_timeout: state %0d", state); end
    vectors++; if (bus.cycle_cnt - c_base !== 32'd10) begin miscompares++; $display("FAIL stale_cycles: got %0d want 10", bus.cycle_cnt - c_base); end
    vectors++;
    if (ev_q.size() != 4) begin
      miscompares++; $display("FAIL stale_pulses: got %0d want 4", ev_q.size());
    end else begin
      vectors++;
      if (ev_q[1] != 1 || ev_q[2] != 2 || ev_stamp[2] - ev_stamp[1] != 4) begin
        miscompares++; $display("FAIL stale_decode_wait: stages %0d,%0d gap %0d want 1,2 gap 4", ev_q[1], ev_q[2], ev_stamp[2] - ev_stamp[1]);
      end
    end
    vectors++; if (bus.pc !== 32'h10c) begin miscompares++; $display("FAIL stale_pc: got %h want 0000010c", bus.pc); end
    stale_f = 1'b0; lat[1] = 1;
  endtask

  task automatic test_watchdog_edge();
    bit ok;
    logic [31:0] c_base;
    c_base = bus.cycle_cnt;
    lat[2] = 8;
    exp_q.push_back(32'h10c);
    bus.run = 1'b1;
    step(1);
    bus.run = 1'b0;
    wait_state(S_IDLE, 40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wde_idle_timeout: state %0d want IDLE", state); end
    vectors++; if (bus.error !== 1'b0) begin miscompares++; $display("FAIL wde_error: got %b want 0", bus.error); end
    vectors++; if (bus.cycle_cnt - c_base !== 32'd15) begin miscompares++; $display("FAIL wde_cycles: got %0d want 15", bus.cycle_cnt - c_base); end
    vectors++; if (bus.pc !== 32'h110) begin miscompares++; $display("FAIL wde_pc: got %h want 00000110", bus.pc); end
    lat[2] = 1;
  endtask

  task automatic test_idle_halt();
    int p_base;
    p_base = pulse_total;
    bus.run = 1'b1; bus.halt_req = 1'b1;
    step(1);
    vectors++; if (state !== S_HALTED || bus.halted !== 1'b1) begin miscompares++; $display("FAIL ihalt_state: state %0d halted %b want HALTED/1", state, bus.halted); end
    bus.halt_req = 1'b0;
    step(4);
    vectors++; if (pulse_total != p_base) begin miscompares++; $display("FAIL ihalt_pulses: got %0d want %0d", pulse_total, p_base); end
    vectors++; if (bus.pc !== 32'h110) begin miscompares++; $display("FAIL ihalt_pc: got %h want 00000110", bus.pc); end
    reset_dut();
  endtask

  task automatic test_halt();
    bit ok;
    logic [31:0] c_snap;
    int p_base;
    exp_q.push_back(32'h0);
    bus.run = 1'b1;
    wait_state(S_E_WAIT, 20, ok);
    bus.halt_req = 1'b1;
    wait_state(S_HALTED, 20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL halt_timeout: state %0d want HALTED", state); end
    vectors++; if (bus.instret_cnt !== 32'd1) begin miscompares++; $display("FAIL halt_retired: got %0d want 1", bus.instret_cnt); end
    vectors++; if (bus.pc !== 32'h4 || bus.halted !== 1'b1) begin miscompares++; $display("FAIL halt_pc: pc %h halted %b want 00000004/1", bus.pc, bus.halted); end
    c_snap = bus.cycle_cnt; p_base = pulse_total;
    bus.halt_req = 1'b0;
    step(5);
    vectors++;
    if (bus.pc !== 32'h4 || pulse_total != p_base || bus.cycle_cnt !== c_snap || state !== S_HALTED) begin
      miscompares++; $display("FAIL halt_sticky: pc %h pulses %0d cycle %0d state %0d", bus.pc, pulse_total - p_base, bus.cycle_cnt, state);
    end
    reset_dut();
    vectors++;
    if (state !== S_IDLE || bus.pc !== 32'h0 || bus.halted !== 1'b0 || bus.instret_cnt !== 32'd0) begin
      miscompares++; $display("FAIL halt_reset: state %0d pc %h halted %b instret %0d", state, bus.pc, bus.halted, bus.instret_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int p_base;
    reset_dut();
    never_c[2] = 1'b1;
    exp_q.push_back(32'h0);
    bus.run = 1'b1;
    wait_state(S_E_WAIT, 20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL to_ewait_timeout: state %0d", state); end
    step(7);
    vectors++; if (bus.error !== 1'b0 || state !== S_E_WAIT) begin miscompares++; $display("FAIL to_early: error %b state %0d want 0/E_WAIT", bus.error, state); end
    step(1);
    vectors++; if (bus.error !== 1'b1 || state !== S_ERROR) begin miscompares++; $display("FAIL to_error: error %b state %0d want 1/ERROR", bus.error, state); end
    vectors++; if (bus.err_stage !== STG_E) begin miscompares++; $display("FAIL to_err_stage: got %0d want 2", bus.err_stage); end
    p_base = pulse_total;
    for (int i = 0; i < 8; i++) begin
      bus.run = 1'($urandom_range(0, 1));
      step(1);
    end
    vectors++; if (pulse_total != p_base || state !== S_ERROR) begin miscompares++; $display("FAIL to_sticky: pulses %0d state %0d", pulse_total - p_base, state); end
    never_c[2] = 1'b0;
    reset_dut();
    vectors++; if (bus.error !== 1'b0 || bus.err_stage !== 3'd0 || state !== S_IDLE) begin miscompares++; $display("FAIL to_reset: error %b err_stage %0d state %0d", bus.error, bus.err_stage, state); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rstn = 1'b0; bus.run = 1'b0; bus.halt_req = 1'b0;
    test_reset();
    test_sequential();
    test_mem();
    test_jump();
    test_stale_fetch();
    test_watchdog_edge();
    test_idle_halt();
    test_halt();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control unit of the core. It steps one instruction at a time through the fetch, decode, exec, mem and write stages, and owns the architectural PC. Each stage is started with a one-cycle enable pulse, and the sequencer then waits for that stage's completed level. It also handles run/halt control, a per-stage watchdog, and cycle and retired-instruction counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 1024, maximum cycles spent in any WAIT state before ERROR; 0 disables the watchdog.
CNT_W, 32, width of cycle_cnt and instret_cnt.

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
run  in  1  level; allows a new instruction to start at an instruction boundary
halt_req  in  1  level; requests a sticky halt at the next instruction boundary
pc  out  32  current instruction address; stable from F_ISSUE through W_WAIT
fetch_enabled / decode_enabled / exec_enabled / mem_enabled / write_enabled  out  1 each  one-cycle start pulses
fetch_completed / decode_completed / exec_completed / mem_completed / write_completed  in  1 each  stage-done levels
decode_is_mem  in  1  qualified by decode_completed; the instruction needs the mem stage
exec_is_jump  in  1  qualified by exec_completed; redirect the PC
exec_jump_dest  in  32  qualified by exec_completed; redirect target
halted  out  1  sticky halt indicator
error  out  1  sticky watchdog-timeout indicator
err_stage  out  3  stage index that timed out (0=F, 1=D, 2=E, 3=M, 4=W)
cycle_cnt  out  CNT_W  number of active cycles
instret_cnt  out  CNT_W  number of retired instructions

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE, pc=RESET_PC, all enables 0.
  - halted=0, error=0, err_stage=0, counters=0.
  - Latched is_mem / is_jump / dest cleared; watchdog cleared.
  - Reset in the middle of an instruction abandons it; no retire count.
- States: IDLE, F_ISSUE, F_WAIT, D_ISSUE, D_WAIT, E_ISSUE, E_WAIT, M_ISSUE, M_WAIT, W_ISSUE, W_WAIT, HALTED, ERROR.
- Enable outputs are Moore outputs: X_enabled=1 only in X_ISSUE, so each pulse is exactly one cycle wide.
- X_ISSUE always moves to X_WAIT unconditionally.
- Completed inputs are sampled only in the matching X_WAIT state. A completed level seen in any other state is ignored, including stale levels held high after the previous use.
- Stage transitions:
  - F_WAIT on fetch_completed -> D_ISSUE.
  - D_WAIT on decode_completed -> latch decode_is_mem, then go to E_ISSUE.
  - E_WAIT on exec_completed -> latch is_jump and dest, then go to M_ISSUE if the latched is_mem=1, otherwise W_ISSUE.
  - M_WAIT on mem_completed -> W_ISSUE.
- W_WAIT on write_completed (retire):
  - pc <= latched is_jump ? latched dest : pc+4 (mod 2^32).
  - instret_cnt++.
  - Next state: HALTED if halt_req; else F_ISSUE if run; else IDLE.
- IDLE: halt_req -> HALTED (priority), else run -> F_ISSUE, else stay.
- HALTED and ERROR are sticky until reset. halted=1 in HALTED; error=1 in ERROR.
- halt_req and run are not looked at mid-instruction.
- Watchdog:
  - Counter clears on entry to every X_WAIT and increments each WAIT cycle without completion.
  - When TIMEOUT!=0 and the count reaches TIMEOUT, go to ERROR and record err_stage.
  - Completion in the same cycle as the timeout wins.
- cycle_cnt increments every cycle the state is not IDLE, HALTED or ERROR. Both counters wrap modulo 2^CNT_W.
- Latency, with every stage completing the cycle after its pulse:
  - 10 cycles per instruction with mem.
  - 8 cycles per instruction without mem.
  - Back-to-back instructions have no bubble: W_WAIT goes straight to F_ISSUE.

Decomposition:
- Shared package core_seq_pkg holds:
  - the state enum (4-bit);
  - the stage-index constants STG_F..STG_W (3-bit);
  - the PC increment constant 4.
- One natural sub-module, seq_watchdog: takes clear, tick and TIMEOUT, and outputs expired.
- The rest stays flat in core_sequencer.

Test Plan:
1. Reset, run=1; stage models complete 1 cycle after their pulse; decode_is_mem=0, no jumps -> pc goes 0, 4, 8, one instruction every 8 cycles, no mem pulse, instret_cnt=3 after 24 cycles.
2. decode_is_mem=1 on the 2nd instruction -> exactly one mem_enabled pulse between the exec and write pulses; that instruction takes 10 cycles.
3. exec_is_jump=1 with exec_jump_dest=32'h0000_0100 at pc=4 -> next fetch_enabled sees pc=32'h100, then 32'h104.
4. Fetch model holds completed high permanently (stale) -> the sequencer still waits through D_WAIT for decode_completed; no stage is skipped.
5. halt_req asserted during E_WAIT -> the instruction still retires, then halted=1 and the PC is frozen; a reset pulse returns to IDLE with pc=RESET_PC.
6. TIMEOUT=8 and exec never completes -> error=1 exactly 8 cycles after entering E_WAIT, err_stage=2, no further enables; run toggling has no effect until reset.
